gcd_host_ctrl: RTL

Host-side command controller that sits directly upstream of the register file's GCD operand/start inputs and downstream of its writeback port.
- Accepts a GCD request from an external host over a valid/ready handshake.
- Holds the operands on gcd_a/gcd_b and raises calc_start for the firmware to poll.
- Watches the writeback bus for the firmware's final write to x10.
- Returns that value, or a timeout error, over a valid/ready response handshake.

---
 rtl/rv32i_pkg.sv | 28 ++
 rtl/gcd_host_ctrl_if.sv | 34 +++
 rtl/gcd_host_ctrl_timeout_cnt.sv | 40 ++++
 rtl/gcd_host_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the GCD host controller slice.
//   - Register-file addresses used by the GCD firmware.
//   - Host-controller FSM state encoding.
//   - Helper that recognises the firmware's completing writeback.
package rv32i_pkg;

  // Register-file addresses the GCD firmware uses.
  localparam logic [4:0] GCD_A      = 5'd28;
  localparam logic [4:0] GCD_B      = 5'd29;
  localparam logic [4:0] GCD_RESULT = 5'd10;
  localparam logic [4:0] GCD_START  = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } gcd_state_e;

  // True when a writeback lands on the result register. x0 is hard-wired
  // to zero in the core, so a write to it can never carry a result, even
  // if the result register is configured as 0.
  function automatic logic is_result_write(input logic       we,
                                           input logic [4:0] addr,
                                           input logic [4:0] result_reg);
    return we && (addr == result_reg) && (addr != 5'd0);
  endfunction

endpackage

// File: rtl/gcd_host_ctrl_if.sv
// Host-side request/response bundle of the GCD host controller.
//   master : the external host (drives requests, accepts responses)
//   slave  : gcd_host_ctrl (accepts requests, returns responses)
// Signals:
//   req_valid/req_ready      request handshake
//   req_a/req_b              request operands
//   resp_valid/resp_ready    response handshake
//   resp_result/resp_err     GCD result (0 on error) and timeout flag
//   cycles_used              RUN cycles spent on the last request
interface gcd_host_ctrl_if #(
  parameter int CNT_W = 32
) ();

  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_result;
  logic             resp_err;
  logic [CNT_W-1:0] cycles_used;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_err, cycles_used
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_err, cycles_used
  );

endinterface

// File: rtl/gcd_host_ctrl_timeout_cnt.sv
// gcd_timeout_cnt: saturating up-counter for the RUN-state timeout.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clr         load zero (wins over en)
//   en          increment by one, sticking at all-ones
//   count       current count
//   tc          terminal count: count+1 equals TIMEOUT_CYCLES
module gcd_timeout_cnt #(
  parameter int          CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;

  // NOTE: the reset is synchronous, so it lives inside the clocked branch
  // and rst_n is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !(&count_q)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

  // Compare at 64 bits so count+1 cannot wrap to a false match; once the
  // counter sticks at all-ones a timeout larger than 2^CNT_W never fires.
  assign tc = ((64'(count_q) + 64'd1) == 64'(TIMEOUT_CYCLES));

endmodule

// File: rtl/gcd_host_ctrl.sv
// gcd_host_ctrl: host command controller for the firmware GCD engine.
// Accepts an operand pair from the host, presents it to the register file
// with a level start flag, waits for the firmware to write the result
// register, and returns that value (or a timeout error) to the host.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   host         gcd_host_ctrl_if.slave request/response bundle
//   wb_we/addr/data  register-file writeback bus (observed only)
//   gcd_a/gcd_b  held operands to the register file
//   calc_start   start flag to the register file, high during RUN
//   busy         high in RUN and RESP
// TIMEOUT_CYCLES must be at least 2.
module gcd_host_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int          CNT_W          = 32,
  parameter logic [4:0]  RESULT_REG     = GCD_RESULT
) (
  input  logic        clk,
  input  logic        rst_n,
  gcd_host_ctrl_if.slave host,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] gcd_a,
  output logic [31:0] gcd_b,
  output logic        calc_start,
  output logic        busy
);

  gcd_state_e state_q, state_d;

  logic [31:0]      gcd_a_q, gcd_a_d;
  logic [31:0]      gcd_b_q, gcd_b_d;
  logic             calc_start_q, calc_start_d;
  logic             busy_q, busy_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_result_q, resp_result_d;
  logic             resp_err_q, resp_err_d;
  logic [CNT_W-1:0] cycles_used_q, cycles_used_d;

  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt, cnt_plus1;

  logic accept, done, resp_hs;

  assign accept  = (state_q == IDLE) && host.req_valid;
  assign done    = is_result_write(wb_we, wb_addr, RESULT_REG);
  assign resp_hs = resp_valid_q && host.resp_ready;

  // cycles_used reports count+1, held at all-ones rather than wrapping.
  assign cnt_plus1 = (&cnt) ? cnt : cnt + CNT_W'(1);

  gcd_timeout_cnt #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(cnt),
    .tc   (cnt_tc)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)            state_d = RUN;
      RUN:     if (done || cnt_tc)    state_d = RESP;
      RESP:    if (resp_hs)           state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and counter control.
  always_comb begin
    gcd_a_d       = gcd_a_q;
    gcd_b_d       = gcd_b_q;
    calc_start_d  = calc_start_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
    cycles_used_d = cycles_used_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          gcd_a_d      = host.req_a;
          gcd_b_d      = host.req_b;
          calc_start_d = 1'b1;
          cnt_clr      = 1'b1;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        // Completion is checked first so a result arriving on the timeout
        // cycle is still delivered without an error.
        if (done) begin
          resp_result_d = wb_data;
          resp_err_d    = 1'b0;
          cycles_used_d = cnt_plus1;
          calc_start_d  = 1'b0;
          resp_valid_d  = 1'b1;
        end else if (cnt_tc) begin
          resp_result_d = '0;
          resp_err_d    = 1'b1;
          cycles_used_d = cnt_plus1;
          calc_start_d  = 1'b0;
          resp_valid_d  = 1'b1;
        end
      end
      RESP: begin
        if (resp_hs) resp_valid_d = 1'b0;
      end
      default: begin
        calc_start_d = 1'b0;
        resp_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Registered outputs. A reset mid-request drops everything, so no
  // response is ever issued for the aborted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gcd_a_q       <= '0;
      gcd_b_q       <= '0;
      calc_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
      cycles_used_q <= '0;
    end else begin
      gcd_a_q       <= gcd_a_d;
      gcd_b_q       <= gcd_b_d;
      calc_start_q  <= calc_start_d;
      busy_q        <= busy_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
      cycles_used_q <= cycles_used_d;
    end
  end

  assign gcd_a      = gcd_a_q;
  assign gcd_b      = gcd_b_q;
  assign calc_start = calc_start_q;
  assign busy       = busy_q;

  assign host.req_ready   = (state_q == IDLE);
  assign host.resp_valid  = resp_valid_q;
  assign host.resp_result = resp_result_q;
  assign host.resp_err    = resp_err_q;
  assign host.cycles_used = cycles_used_q;

endmodule
